code_seq_lock: RTL
==================

Name: code_seq_lock

Overview:
Sequential, parametrised successor to the combinational code-decoder controller. It accepts a stream of keyed codes and compares them against a fixed secret sequence of SEQ_LEN digits. It drives three outputs: lock (o_L), alarm (o_A) and busy/lockout (o_B). It also provides auto-relock, failed-attempt counting and a timed lockout. It sits between the keypad front-end and the actuator/alarm drivers.

Parameters:
CODE_W, 4, width of one code digit
SEQ_LEN, 3, digits per entry attempt (>=1)
SECRET, {4'hB,4'hA,4'h3}, SEQ_LEN*CODE_W bits; digit 0 in LSBs, entered first (order 3, A, B)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYC, 16, lockout duration in clock cycles (>=1)
UNLOCK_CYC, 32, cycles before auto-relock from unlocked (>=1)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  block enable
i_valid  in  1  one-cycle strobe: i_code holds a new digit
i_code  in  CODE_W  entered digit
i_clear  in  1  abort entry / manual relock
o_L  out  1  1 = locked
o_A  out  1  alarm, high throughout lockout
o_B  out  1  busy: high in LOCKOUT
o_idx  out  clog2(SEQ_LEN+1)  digits accepted in the current attempt
o_fail  out  clog2(MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- One clock; reset is asynchronous and active-low (i_rst_n). All state and outputs are registered.
- Reset values: state=IDLE, o_L=1, o_A=0, o_B=0, o_idx=0, o_fail=0, mismatch flag=0, timers=0.
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT.
- Accept event = i_en & i_valid, in IDLE or ENTRY only; otherwise i_valid is ignored.
- On accept:
  - Compare i_code with SECRET digit o_idx. OR any mismatch into a sticky flag.
  - No early abort on a wrong digit; a full SEQ_LEN entry is always required.
  - IDLE -> ENTRY on the first digit.
- Last digit (o_idx = SEQ_LEN-1 on accept), evaluated at the same edge including that digit's compare:
  - All match -> UNLOCKED. o_L=0, o_fail=0, unlock timer=UNLOCK_CYC.
  - Mismatch with o_fail+1 < MAX_FAIL -> IDLE, o_fail increments.
  - Mismatch with o_fail+1 = MAX_FAIL -> LOCKOUT. o_A=1, o_B=1, o_fail=MAX_FAIL, lockout timer=LOCKOUT_CYC.
  - o_idx and the mismatch flag clear in all three cases.
- Latency: outputs change on the clock edge that accepts the final digit and are visible in the following cycle.
- ENTRY aborts:
  - i_clear=1 or i_en=0 -> IDLE, o_idx=0, mismatch flag cleared, o_fail unchanged (no fail counted).
  - i_clear takes priority over a simultaneous i_valid; that digit is discarded.
- UNLOCKED:
  - The unlock timer decrements each cycle regardless of i_en.
  - i_clear=1, or a timer value of 1 at the edge, -> IDLE with o_L=1. Exactly UNLOCK_CYC cycles unlocked without clear.
  - Digits are ignored.
- LOCKOUT:
  - All inputs are ignored, including i_clear and i_en.
  - The timer decrements every cycle. At timer=1 at the edge -> IDLE with o_A=0, o_B=0, o_fail=0.
  - o_A and o_B are high for exactly LOCKOUT_CYC cycles.
- IDLE: i_clear has no effect. o_fail persists until an unlock or the end of a lockout.
- A successful unlock resets o_fail, even after MAX_FAIL-1 failures.
- i_rst_n low in any state, including mid-lockout, immediately forces the reset values.
- Counter widths are sized from the parameters; no wrap-around is reachable.

Test Plan:
- Reset, then i_en=1 and digits 3,A,B (one strobe each, with gaps) -> o_idx goes 1,2 then 0; o_L=0 the cycle after B; o_L returns to 1 after exactly 32 cycles.
- Unlock, then i_clear pulse at cycle 5 -> o_L=1 next cycle, state IDLE; digits sent during unlocked do not change o_idx.
- Enter 3,A,C -> o_L stays 1, o_fail=1. Then 3,A,B -> unlock, o_fail=0.
- Three wrong entries (F,F,F x3) -> after the ninth digit o_A=1, o_B=1, o_fail=3 for exactly 16 cycles. Digits 3,A,B and i_clear during lockout are ignored. Afterwards o_A=0, o_B=0, o_fail=0, o_L=1.
- Enter 3,A, then drop i_en -> o_idx=0, o_fail unchanged. Repeat with i_clear asserted in the same cycle as i_valid for B -> digit discarded, o_L=1.
- Assert i_rst_n=0 asynchronously mid-lockout (cycle 7) and mid-entry -> all outputs take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/code_seq_lock.sv
// Sequential code lock: compares a keyed digit stream against a secret sequence,
// with auto-relock, consecutive-failure counting and a timed alarm lockout.
module code_seq_lock #(
    parameter int                          CODE_W      = 4,
    parameter int                          SEQ_LEN     = 3,
    parameter logic [SEQ_LEN*CODE_W-1:0]   SECRET      = {4'hB, 4'hA, 4'h3},
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16,
    parameter int                          UNLOCK_CYC  = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_en,
    input  logic                               i_valid,
    input  logic [CODE_W-1:0]                  i_code,
    input  logic                               i_clear,
    output logic                               o_L,
    output logic                               o_A,
    output logic                               o_B,
    output logic [$clog2(SEQ_LEN+1)-1:0]       o_idx,
    output logic [$clog2(MAX_FAIL+1)-1:0]      o_fail
);

    localparam int IDX_W   = $clog2(SEQ_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t              state_q;
    logic                l_q;
    logic                a_q;
    logic                b_q;
    logic [IDX_W-1:0]    idx_q;
    logic [FAIL_W-1:0]   fail_q;
    logic                mis_q;
    logic [TMR_W-1:0]    tmr_q;

    logic [CODE_W-1:0]   secret_digit [SEQ_LEN];
    logic                accept;
    logic                mis_d;
    logic                last_digit;
    logic                lock_hit;

    generate
        for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_digit
            assign secret_digit[gi] = SECRET[gi*CODE_W +: CODE_W];
        end
    endgenerate

    assign accept     = i_en & i_valid;
    // Mismatch including the digit being accepted this cycle.
    assign mis_d      = mis_q | (i_code != secret_digit[idx_q]);
    assign last_digit = (idx_q == IDX_W'(SEQ_LEN - 1));
    assign lock_hit   = (fail_q == FAIL_W'(MAX_FAIL - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            idx_q   <= '0;
            fail_q  <= '0;
            mis_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (state_q == ST_ENTRY && (i_clear || !i_en)) begin
                        // Aborted attempt: discard progress, no failure counted.
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        mis_q   <= 1'b0;
                    end else if (accept) begin
                        if (last_digit) begin
                            idx_q <= '0;
                            mis_q <= 1'b0;
                            if (!mis_d) begin
                                state_q <= ST_UNLOCKED;
                                l_q     <= 1'b0;
                                fail_q  <= '0;
                                tmr_q   <= TMR_W'(UNLOCK_CYC);
                            end else if (lock_hit) begin
                                state_q <= ST_LOCKOUT;
                                a_q     <= 1'b1;
                                b_q     <= 1'b1;
                                fail_q  <= FAIL_W'(MAX_FAIL);
                                tmr_q   <= TMR_W'(LOCKOUT_CYC);
                            end else begin
                                state_q <= ST_IDLE;
                                fail_q  <= fail_q + 1'b1;
                            end
                        end else begin
                            state_q <= ST_ENTRY;
                            idx_q   <= idx_q + 1'b1;
                            mis_q   <= mis_d;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (i_clear || tmr_q == TMR_W'(1)) begin
                        state_q <= ST_IDLE;
                        l_q     <= 1'b1;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_q == TMR_W'(1)) begin
                        state_q <= ST_IDLE;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        fail_q  <= '0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_L    = l_q;
    assign o_A    = a_q;
    assign o_B    = b_q;
    assign o_idx  = idx_q;
    assign o_fail = fail_q;

endmodule
